// File: rtl/window_power_meter_pkg.sv
// window_power_meter_pkg: shared constants and accumulator sizing for the power meter
package window_power_meter_pkg;
  localparam int SHIFT = 10;
  localparam int MAXLOG = 12;
  function automatic int accw(input int dw, input int maxlog);
    return 2 * dw - 1 + maxlog;
  endfunction
endpackage

// File: rtl/window_power_meter_sq_pipe.sv
// window_power_meter_sq_pipe: one-cycle registered signed squarer with unsigned output
module window_power_meter_sq_pipe #(
  parameter int DW = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic signed [DW-1:0] x,
  input  logic                 x_valid,
  output logic [2*DW-2:0]      sq,
  output logic                 sq_valid
);
  localparam int PW = 2 * DW - 1;
  logic [DW-1:0] mag;
  logic [PW-1:0] sq_c;
  // magnitude first so the most negative input (-2^(DW-1)) squares to 2^(2*DW-2) without a sign bit
  always_comb begin
    mag = x[DW-1] ? -x : x;
    sq_c = PW'(mag) * PW'(mag);
  end
  // product register; enable low drops the valid so nothing reaches the accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq <= '0;
      sq_valid <= 1'b0;
    end else begin
      sq <= sq_c;
      sq_valid <= enable & x_valid;
    end
  end
endmodule

// File: rtl/window_power_meter.sv
// window_power_meter: mean-square power of a signed stream over a power-of-two window
module window_power_meter #(
  parameter int DW = 18,
  parameter int OW = 24,
  parameter int SHIFT = window_power_meter_pkg::SHIFT,
  parameter int MAXLOG = window_power_meter_pkg::MAXLOG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic signed [DW-1:0] x_in,
  input  logic                 x_valid,
  input  logic [3:0]           log2_win,
  output logic [OW-1:0]        data_out,
  output logic                 data_s,
  output logic                 sat
);
  import window_power_meter_pkg::*;
  localparam int ACCW = accw(DW, MAXLOG);
  localparam int CW = MAXLOG + 1;
  localparam int PW = 2 * DW - 1;
  logic signed [DW-1:0] s1_x;
  logic s1_v;
  logic [PW-1:0] s2_sq;
  logic s2_v;
  logic [ACCW-1:0] acc, sum, fin, res;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0] win_l, l_cur, lw_clamp, fin_l;
  logic close, fin_v, ovf;
  // S1: capture the raw sample and its qualifier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_x <= '0;
      s1_v <= 1'b0;
    end else begin
      s1_x <= x_in;
      s1_v <= enable & x_valid;
    end
  end
  window_power_meter_sq_pipe #(.DW(DW)) u_sq (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .x(s1_x),
    .x_valid(s1_v),
    .sq(s2_sq),
    .sq_valid(s2_v)
  );
  // window length comes live from log2_win on a window's first sample, otherwise from the latch
  always_comb begin
    lw_clamp = (log2_win > 4'(MAXLOG)) ? 4'(MAXLOG) : log2_win;
    l_cur = (cnt == '0) ? lw_clamp : win_l;
    sum = acc + ACCW'(s2_sq);
    cnt_nx = cnt + CW'(1);
    close = s2_v && (cnt_nx == (CW'(1) << l_cur));
    res = fin >> (int'(fin_l) + SHIFT);
    ovf = |res[ACCW-1:OW];
  end
  // S3: accumulate; on close hand the final sum onward and restart from zero on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      win_l <= '0;
      fin <= '0;
      fin_l <= '0;
      fin_v <= 1'b0;
    end else if (!enable) begin
      acc <= '0;
      cnt <= '0;
      fin_v <= 1'b0;
    end else begin
      fin_v <= close;
      if (s2_v) begin
        acc <= close ? '0 : sum;
        cnt <= close ? '0 : cnt_nx;
        win_l <= l_cur;
      end
      if (close) begin
        fin <= sum;
        fin_l <= l_cur;
      end
    end
  end
  // output register: scale, saturate and strobe once per closed window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      data_s <= 1'b0;
      sat <= 1'b0;
    end else begin
      data_s <= fin_v & enable;
      if (fin_v & enable) begin
        data_out <= ovf ? '1 : res[OW-1:0];
        sat <= ovf;
      end
    end
  end
endmodule

// File: tb/tb_window_power_meter.sv
// tb_window_power_meter: directed vector table plus corner sequences for window_power_meter
module tb_window_power_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic x_valid = 1'b0;
  logic signed [17:0] x_in = '0;
  logic [3:0] log2_win = '0;
  logic [23:0] data_out;
  logic data_s, sat;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vcyc[$];
  int ends[$];
  typedef struct {int c; logic [23:0] d; logic s;} strb_t;
  strb_t sq[$];
  typedef struct {
    logic signed [17:0] x;
    bit alt;
    logic [3:0] lw;
    int w;
    int n;
    int gap;
    int nw;
    logic [23:0] exp;
    bit esat;
  } vec_t;
  vec_t vt[8];
  window_power_meter dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .x_in(x_in),
    .x_valid(x_valid),
    .log2_win(log2_win),
    .data_out(data_out),
    .data_s(data_s),
    .sat(sat)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (data_s) sq.push_back('{cyc, data_out, sat});
  task automatic cmp(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask
  task automatic step(input logic signed [17:0] x, input logic v);
    @(negedge clk);
    x_in = x;
    x_valid = v;
    if (v) vcyc.push_back(cyc + 1);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0);
  endtask
  task automatic feed(input logic signed [17:0] x, input bit alt, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int g = 1; g < gap; g++) step('0, 1'b0);
      step((alt && i[0]) ? -x : x, 1'b1);
    end
    step('0, 1'b0);
  endtask
  task automatic check(input string nm, input logic [23:0] e, input bit es);
    idle(6);
    cmp({nm, " count"}, sq.size(), ends.size());
    for (int k = 0; k < sq.size() && k < ends.size(); k++) begin
      cmp({nm, " lat"}, sq[k].c, vcyc[ends[k]] + 3);
      cmp({nm, " data"}, sq[k].d, e);
      cmp({nm, " sat"}, sq[k].s, es);
    end
    sq.delete();
    vcyc.delete();
    ends.delete();
  endtask
  task automatic restart();
    @(negedge clk);
    enable = 1'b0;
    x_valid = 1'b0;
    idle(2);
    enable = 1'b1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end
  initial begin
    vt[0] = '{18'sd1024, 1'b0, 4'd4, 16, 32, 5, 2, 24'd1024, 1'b0};
    vt[1] = '{18'sd1000, 1'b1, 4'd3, 8, 400, 1, 50, 24'd976, 1'b0};
    vt[2] = '{18'sd131071, 1'b0, 4'd0, 1, 3, 1, 3, 24'd16776960, 1'b0};
    vt[3] = '{18'h20000, 1'b0, 4'd0, 1, 2, 2, 2, 24'hFFFFFF, 1'b1};
    vt[4] = '{18'sd2048, 1'b0, 4'd4, 16, 16, 1, 1, 24'd4096, 1'b0};
    vt[5] = '{-18'sd3000, 1'b0, 4'd15, 4096, 4096, 1, 1, 24'd8789, 1'b0};
    vt[6] = '{18'sd100, 1'b0, 4'd2, 4, 9, 3, 2, 24'd9, 1'b0};
    vt[7] = '{-18'sd50000, 1'b1, 4'd1, 2, 4, 1, 2, 24'd2441406, 1'b0};
    repeat (3) @(negedge clk);
    cmp("rst data_out", data_out, 0);
    cmp("rst data_s", data_s, 0);
    cmp("rst sat", sat, 0);
    rst = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      log2_win = vt[i].lw;
      feed(vt[i].x, vt[i].alt, vt[i].n, vt[i].gap);
      for (int k = 0; k < vt[i].nw; k++) ends.push_back((k + 1) * vt[i].w - 1);
      check($sformatf("vec%0d", i), vt[i].exp, vt[i].esat);
      restart();
      cmp($sformatf("vec%0d hold", i), data_out, vt[i].exp);
    end
    log2_win = 4'd2;
    feed(18'sd1024, 1'b0, 2, 1);
    idle(3);
    log2_win = 4'd5;
    feed(18'sd1024, 1'b0, 66, 1);
    ends.push_back(3);
    ends.push_back(35);
    ends.push_back(67);
    check("lwchg", 24'd1024, 1'b0);
    restart();
    log2_win = 4'd4;
    feed(18'sd1024, 1'b0, 7, 1);
    #2 rst = 1'b1;
    idle(2);
    rst = 1'b0;
    cmp("rst abort data_out", data_out, 0);
    cmp("rst abort strobes", sq.size(), 0);
    sq.delete();
    vcyc.delete();
    feed(18'sd2048, 1'b0, 16, 1);
    ends.push_back(15);
    check("rst refill", 24'd4096, 1'b0);
    feed(18'sd1024, 1'b0, 7, 1);
    @(negedge clk);
    enable = 1'b0;
    idle(3);
    enable = 1'b1;
    cmp("en abort strobes", sq.size(), 0);
    cmp("en abort hold", data_out, 4096);
    sq.delete();
    vcyc.delete();
    feed(18'sd2048, 1'b0, 16, 1);
    ends.push_back(15);
    check("en refill", 24'd4096, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
